// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_pkg
//  Description : Shared sizes, 7-segment decode table and segment rectangles
//                for the score banner overlay.
//  Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam int COLOR_W = 8;
    localparam int LABEL_W = 32;
    localparam int LABEL_H = 32;
    localparam int DIGIT_W = 8;
    localparam int DIGIT_H = 16;
    localparam int SEG_N   = 7;

    // Lit segments per decimal digit, segment a in bit 6 down to g in bit 0
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011   // 9
    };

    // Inclusive column/row bounds of one segment inside the 8x16 digit box
    typedef struct packed {
        logic [3:0] c_lo;
        logic [3:0] c_hi;
        logic [3:0] r_lo;
        logic [3:0] r_hi;
    } seg_rect_t;

    // Index 0 is segment a, index 6 is segment g
    localparam seg_rect_t SEG_RECT [0:SEG_N-1] = '{
        '{4'd1, 4'd6, 4'd0,  4'd1 },  // a
        '{4'd6, 4'd7, 4'd1,  4'd7 },  // b
        '{4'd6, 4'd7, 4'd8,  4'd14},  // c
        '{4'd1, 4'd6, 4'd14, 4'd15},  // d
        '{4'd0, 4'd1, 4'd8,  4'd14},  // e
        '{4'd0, 4'd1, 4'd1,  4'd7 },  // f
        '{4'd1, 4'd6, 4'd7,  4'd8 }   // g
    };

    // Bit mask with bits lo..hi set; turns a bound pair into a lookup vector
    function automatic logic [15:0] span_mask(input logic [3:0] lo, input logic [3:0] hi);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if ((i >= int'(lo)) && (i <= int'(hi))) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_digit_seg.sv
`default_nettype none
// ============================================================================
//  Module      : score_digit_seg
//  Description : Combinational 7-segment hit test for one local (c,r)
//                position inside an 8x16 digit box.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_digit_seg
    import score_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [2:0] c,
    input  logic [3:0] r,
    output logic       hit
);

    logic [SEG_N-1:0] w_segs;
    logic [SEG_N-1:0] w_in_rect;

    // Decode the digit; out-of-range values draw nothing
    always_comb begin
        w_segs = '0;
        if (digit <= 4'd9) w_segs = SEG_LUT[digit];
    end

    for (genvar i = 0; i < SEG_N; i++) begin : g_seg
        localparam logic [15:0] c_col_mask = span_mask(SEG_RECT[i].c_lo, SEG_RECT[i].c_hi);
        localparam logic [15:0] c_row_mask = span_mask(SEG_RECT[i].r_lo, SEG_RECT[i].r_hi);
        assign w_in_rect[SEG_N-1-i] = c_col_mask[{1'b0, c}] & c_row_mask[r];
    end

    assign hit = |(w_segs & w_in_rect);

endmodule
`default_nettype wire

// File: rtl/score_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : score_overlay
//  Description : Score banner for the tic-tac-toe VGA display. Keeps the win
//                counters, addresses the label glyph ROM and merges the ROM
//                colour with two drawn 7-segment digits (2-clock latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module score_overlay
    import score_pkg::*;
#(
    parameter logic [9:0]         LABEL_X0  = 10'd16,
    parameter logic [9:0]         LABEL_Y0  = 10'd16,
    parameter logic [9:0]         DIGIT_GAP = 10'd4,
    parameter logic [COLOR_W-1:0] X_COLOR   = 8'hE0,
    parameter logic [COLOR_W-1:0] O_COLOR   = 8'h03,
    parameter logic [COLOR_W-1:0] BG_COLOR  = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_win,
    input  logic               o_win,
    input  logic               score_clr,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic               video_on,
    output logic [9:0]         rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] pixel_out,
    output logic [3:0]         x_score,
    output logic [3:0]         o_score
);

    localparam logic [9:0] c_x_box_x0 = LABEL_X0 + 10'(LABEL_W) + DIGIT_GAP;
    localparam logic [9:0] c_o_box_x0 = c_x_box_x0 + 10'(DIGIT_W) + DIGIT_GAP;

    logic               r_x_win_d, r_o_win_d;
    logic [3:0]         r_x_score, r_o_score;
    logic [9:0]         r_rom_addr;
    logic               r_in_label_d, r_x_hit_d, r_o_hit_d, r_video_on_d;
    logic [COLOR_W-1:0] r_pixel_out;

    logic       w_inc_x, w_inc_o;
    logic [9:0] w_dx, w_dy, w_xdx, w_odx;
    logic       w_in_label, w_in_row, w_x_box, w_o_box;
    logic       w_x_seg, w_o_seg;

    assign w_inc_x = x_win & ~r_x_win_d;
    assign w_inc_o = o_win & ~r_o_win_d;

    // Previous win levels so a held level counts only once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_win_d <= 1'b0;
            r_o_win_d <= 1'b0;
        end else begin
            r_x_win_d <= x_win;
            r_o_win_d <= o_win;
        end
    end

    // Saturating win counters; clear beats any increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_score <= 4'd0;
            r_o_score <= 4'd0;
        end else if (score_clr) begin
            r_x_score <= 4'd0;
            r_o_score <= 4'd0;
        end else begin
            if (w_inc_x && (r_x_score != 4'd9)) r_x_score <= r_x_score + 4'd1;
            if (w_inc_o && (r_o_score != 4'd9)) r_o_score <= r_o_score + 4'd1;
        end
    end

    // Window offsets wrap to large values left of/above each feature
    assign w_dx       = pix_x - LABEL_X0;
    assign w_dy       = pix_y - LABEL_Y0;
    assign w_xdx      = pix_x - c_x_box_x0;
    assign w_odx      = pix_x - c_o_box_x0;
    assign w_in_label = (w_dx < 10'(LABEL_W)) && (w_dy < 10'(LABEL_H));
    assign w_in_row   = (w_dy < 10'(DIGIT_H));
    assign w_x_box    = w_in_row && (w_xdx < 10'(DIGIT_W));
    assign w_o_box    = w_in_row && (w_odx < 10'(DIGIT_W));

    score_digit_seg u_x_digit (
        .digit (r_x_score),
        .c     (w_xdx[2:0]),
        .r     (w_dy[3:0]),
        .hit   (w_x_seg)
    );

    score_digit_seg u_o_digit (
        .digit (r_o_score),
        .c     (w_odx[2:0]),
        .r     (w_dy[3:0]),
        .hit   (w_o_seg)
    );

    // Stage 1: ROM address plus the hit flags that travel alongside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr   <= '0;
            r_in_label_d <= 1'b0;
            r_x_hit_d    <= 1'b0;
            r_o_hit_d    <= 1'b0;
            r_video_on_d <= 1'b0;
        end else begin
            r_rom_addr   <= w_in_label ? {w_dy[4:0], w_dx[4:0]} : 10'd0;
            r_in_label_d <= w_in_label;
            r_x_hit_d    <= w_x_box && w_x_seg;
            r_o_hit_d    <= w_o_box && w_o_seg;
            r_video_on_d <= video_on;
        end
    end

    // Stage 2: colour merge, blanking first, then label, X digit, O digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixel_out <= '0;
        end else if (!r_video_on_d) begin
            r_pixel_out <= '0;
        end else if (r_in_label_d) begin
            r_pixel_out <= rom_data;
        end else if (r_x_hit_d) begin
            r_pixel_out <= X_COLOR;
        end else if (r_o_hit_d) begin
            r_pixel_out <= O_COLOR;
        end else begin
            r_pixel_out <= BG_COLOR;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign pixel_out = r_pixel_out;
    assign x_score   = r_x_score;
    assign o_score   = r_o_score;

endmodule
`default_nettype wire

// File: tb/tb_score_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_overlay
//  Description : Randomized scoreboard bench for score_overlay with a
//                geometry-level reference model of the banner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_overlay;

    localparam int         LX0 = 16;
    localparam int         LY0 = 16;
    localparam int         XB0 = LX0 + 32 + 4;  // X digit box column
    localparam int         OB0 = XB0 + 8 + 4;   // O digit box column
    localparam logic [7:0] XC  = 8'hE0;
    localparam logic [7:0] OC  = 8'h03;
    localparam logic [7:0] BG  = 8'h00;

    logic       clk = 1'b0;
    logic       rst, x_win, o_win, score_clr, video_on;
    logic [9:0] pix_x, pix_y, rom_addr;
    logic [7:0] rom_data, pixel_out;
    logic [3:0] x_score, o_score;

    always #5 clk = ~clk;

    score_overlay dut (
        .clk       (clk),
        .rst       (rst),
        .x_win     (x_win),
        .o_win     (o_win),
        .score_clr (score_clr),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .video_on  (video_on),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pixel_out (pixel_out),
        .x_score   (x_score),
        .o_score   (o_score)
    );

    // Label ROM stand-in: all-ones at the directed probe address, hash elsewhere
    function automatic logic [7:0] rom_model(input logic [9:0] a);
        if (a == 10'h065) return 8'hFF;
        return a[7:0] ^ {a[9:8], 6'b101101};
    endfunction

    assign rom_data = rom_model(rom_addr);

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t q_addr[$];
    exp_t q_pix[$];
    exp_t q_score[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int m_x = 0, m_o = 0;
    bit m_xp = 0, m_op = 0;
    bit was_rst = 0;

    string segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    always @(posedge clk) cyc <= cyc + 1;

    // Is local (c,r) of an 8x16 box lit for digit d?
    function automatic bit seg_on(int d, int c, int r);
        string s;
        s = segs[d];
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "a": if (r <= 1 && c >= 1 && c <= 6) return 1;
                "b": if (c >= 6 && r >= 1 && r <= 7) return 1;
                "c": if (c >= 6 && r >= 8 && r <= 14) return 1;
                "d": if (r >= 14 && c >= 1 && c <= 6) return 1;
                "e": if (c <= 1 && r >= 8 && r <= 14) return 1;
                "f": if (c <= 1 && r >= 1 && r <= 7) return 1;
                "g": if (r >= 7 && r <= 8 && c >= 1 && c <= 6) return 1;
                default: ;
            endcase
        end
        return 0;
    endfunction

    function automatic bit in_label(int x, int y);
        return (x >= LX0 && x < LX0 + 32 && y >= LY0 && y < LY0 + 32);
    endfunction

    function automatic int exp_pixel(int x, int y, bit von, int xs, int os);
        if (!von) return 0;
        if (in_label(x, y)) return int'(rom_model(10'((y - LY0) * 32 + (x - LX0))));
        if (y >= LY0 && y < LY0 + 16) begin
            if (x >= XB0 && x < XB0 + 8 && seg_on(xs, x - XB0, y - LY0)) return int'(XC);
            if (x >= OB0 && x < OB0 + 8 && seg_on(os, x - OB0, y - LY0)) return int'(OC);
        end
        return int'(BG);
    endfunction

    // Record expectations for the inputs currently driven, advance the model,
    // then move to #1 after the next rising edge
    task automatic tick();
        int k, x, y;
        k = cyc;
        x = int'(pix_x);
        y = int'(pix_y);
        if (rst) begin
            q_addr.delete();
            q_pix.delete();
            q_score.delete();
            m_x = 0; m_o = 0; m_xp = 0; m_op = 0;
            was_rst = 1;
            q_addr.push_back('{due: k, val: 0});
            q_pix.push_back('{due: k, val: 0});
            q_score.push_back('{due: k, val: 0});
        end else begin
            if (was_rst) begin
                q_addr.push_back('{due: k, val: 0});
                q_pix.push_back('{due: k, val: 0});
                q_pix.push_back('{due: k + 1, val: 0});
                was_rst = 0;
            end
            q_score.push_back('{due: k, val: m_x * 16 + m_o});
            q_addr.push_back('{due: k + 1,
                               val: in_label(x, y) ? (y - LY0) * 32 + (x - LX0) : 0});
            q_pix.push_back('{due: k + 2, val: exp_pixel(x, y, video_on, m_x, m_o)});
            if (score_clr) begin
                m_x = 0;
                m_o = 0;
            end else begin
                if (x_win && !m_xp && m_x < 9) m_x++;
                if (o_win && !m_op && m_o < 9) m_o++;
            end
            m_xp = x_win;
            m_op = o_win;
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops every expectation that has come due
    always @(negedge clk) begin
        exp_t e;
        while (q_addr.size() != 0 && q_addr[0].due <= cyc) begin
            e = q_addr.pop_front();
            n_tests++;
            if (int'(rom_addr) != e.val) begin
                n_fail++;
                $display("FAIL rom_addr cyc=%0d got=%0h exp=%0h", cyc, rom_addr, e.val);
            end
        end
        while (q_pix.size() != 0 && q_pix[0].due <= cyc) begin
            e = q_pix.pop_front();
            n_tests++;
            if (int'(pixel_out) != e.val) begin
                n_fail++;
                $display("FAIL pixel_out cyc=%0d got=%0h exp=%0h", cyc, pixel_out, e.val);
            end
        end
        while (q_score.size() != 0 && q_score[0].due <= cyc) begin
            e = q_score.pop_front();
            n_tests++;
            if (int'(x_score) * 16 + int'(o_score) != e.val) begin
                n_fail++;
                $display("FAIL scores cyc=%0d got=%0d/%0d exp=%0d/%0d",
                         cyc, x_score, o_score, e.val / 16, e.val % 16);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_px(input int x, input int y, input bit von);
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        video_on = von;
    endtask

    task automatic rand_px();
        if ($urandom_range(0, 7) == 0)
            set_px($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1);
        else
            set_px($urandom_range(0, 95), $urandom_range(0, 63), $urandom_range(0, 9) != 0);
    endtask

    task automatic pulse_x();
        x_win = 1'b1; rand_px(); tick();
        x_win = 1'b0; rand_px(); tick();
    endtask

    task automatic pulse_o();
        o_win = 1'b1; rand_px(); tick();
        o_win = 1'b0; rand_px(); tick();
    endtask

    task automatic clear_scores();
        score_clr = 1'b1; rand_px(); tick();
        score_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; x_win = 1'b0; o_win = 1'b0; score_clr = 1'b0;
        set_px(0, 0, 1'b0);
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst = 1'b0;

        // Counting: three X pulses, O held high for ten clocks
        repeat (3) pulse_x();
        o_win = 1'b1;
        repeat (10) begin rand_px(); tick(); end
        o_win = 1'b0; rand_px(); tick();
        chk("count_x3", int'(x_score), 3);
        chk("count_o_held", int'(o_score), 1);

        // Saturation
        repeat (12) pulse_x();
        chk("saturate_x9", int'(x_score), 9);

        // Simultaneous rises from 2/4
        clear_scores();
        repeat (2) pulse_x();
        repeat (4) pulse_o();
        x_win = 1'b1; o_win = 1'b1; rand_px(); tick();
        x_win = 1'b0; o_win = 1'b0; rand_px(); tick();
        chk("simul_x", int'(x_score), 3);
        chk("simul_o", int'(o_score), 5);

        // Rise together with clear
        x_win = 1'b1; score_clr = 1'b1; rand_px(); tick();
        x_win = 1'b0; score_clr = 1'b0; rand_px(); tick();
        chk("clr_prio_x", int'(x_score), 0);
        chk("clr_prio_o", int'(o_score), 0);

        // ROM addressing and left-of-window pixel
        set_px(LX0 + 5, LY0 + 3, 1'b1); tick();
        chk("rom_addr_probe", int'(rom_addr), 10'b0001100101);
        set_px(15, 16, 1'b1); tick();
        chk("pix_rom_ff", int'(pixel_out), 8'hFF);
        set_px(0, 0, 1'b1); tick();
        chk("pix_outside_bg", int'(pixel_out), int'(BG));

        // Digit rendering with x=1, o=8
        pulse_x();
        repeat (8) pulse_o();
        set_px(XB0 + 6, LY0 + 3, 1'b1); tick();
        set_px(XB0 + 0, LY0 + 3, 1'b1); tick();
        set_px(OB0 + 3, LY0 + 7, 1'b1); tick();

        // Blanking inside the label window
        set_px(LX0 + 5, LY0 + 3, 1'b0); tick();
        set_px(LX0 + 20, LY0 + 30, 1'b0); tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            x_win     = ($urandom_range(0, 3) == 0);
            o_win     = ($urandom_range(0, 3) == 0);
            score_clr = ($urandom_range(0, 99) == 0);
            rand_px();
            tick();
        end
        x_win = 1'b0; o_win = 1'b0; score_clr = 1'b0;

        // Mid-line reset with x_score=5
        clear_scores();
        repeat (5) pulse_x();
        repeat (6) begin rand_px(); tick(); end
        chk("pre_reset_x5", int'(x_score), 5);
        set_px(LX0 + 8, LY0 + 8, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_x", int'(x_score), 0);
        chk("async_rst_o", int'(o_score), 0);
        chk("async_rst_pix", int'(pixel_out), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (20) begin rand_px(); tick(); end

        // Drain the pipeline, then everything queued must have been checked
        set_px(0, 0, 1'b0);
        repeat (4) tick();
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", q_addr.size() + q_pix.size() + q_score.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
